// File: rtl/bwt_stream_ctrl.sv
// bwt_stream_ctrl: one-frame-in-flight sequencer in front of the bwt_top core.
// Buffers an upstream frame, bursts it into the core, collects the result and drains it downstream.
module bwt_stream_ctrl #(
    parameter int STRING_LEN = 8,
    parameter int CHAR_W     = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHAR_W-1:0] s_data,
    input  logic              s_last,
    output logic              core_start,
    output logic [CHAR_W-1:0] core_char,
    input  logic [CHAR_W-1:0] core_out_char,
    input  logic              core_valid_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CHAR_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err_len,
    output logic              err_timeout
);
    localparam int CW = $clog2(STRING_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(STRING_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(STRING_LEN - 1);
    localparam logic [CW-1:0] FULL     = CW'(STRING_LEN);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {LOAD, DROP, FEED, COLLECT, DRAIN} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     k_cnt, j_cnt, n_cnt, p_cnt, j_nxt;
    logic [TW-1:0]     t_cnt;
    logic [CHAR_W-1:0] ibuf [STRING_LEN];
    logic [CHAR_W-1:0] obuf [STRING_LEN];

    logic              s_fire, m_fire, capture, full_now, feed_last;
    logic              s_ready_d, core_start_d, err_len_d, err_timeout_d;
    logic [CHAR_W-1:0] core_char_d;

    // Both streams: a beat transfers on a clock edge where valid && ready are both high;
    // the producer holds valid and payload unchanged until that edge.
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign capture   = core_valid_out && (state == FEED || state == COLLECT) && (n_cnt != FULL);
    assign full_now  = (n_cnt == FULL) || (capture && n_cnt == LAST_IDX);
    assign feed_last = (j_cnt == LAST_IDX);
    assign j_nxt     = j_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            s_ready     <= 1'b0;
            core_start  <= 1'b0;
            core_char   <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= next_state;
            s_ready     <= s_ready_d;
            core_start  <= core_start_d;
            core_char   <= core_char_d;
            err_len     <= err_len_d;
            err_timeout <= err_timeout_d;
        end
    end

    // Completion is tested before the timeout so a final beat on the last allowed cycle wins.
    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (s_fire && k_cnt == LAST_IDX) next_state = s_last ? FEED : DROP;
            DROP:    if (s_fire && s_last) next_state = LOAD;
            FEED:    if (feed_last) next_state = full_now ? DRAIN : COLLECT;
            COLLECT: begin
                if (full_now) next_state = DRAIN;
                else if (t_cnt == T_LAST) next_state = LOAD;
            end
            DRAIN:   if (m_fire && p_cnt == LAST_IDX) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        busy    = (state != LOAD);
        m_valid = (state == DRAIN);
        m_data  = '0;
        m_last  = 1'b0;
        if (state == DRAIN) begin
            m_data = obuf[p_cnt[IW-1:0]];
            m_last = (p_cnt == LAST_IDX);
        end
        s_ready_d    = (next_state == LOAD) || (next_state == DROP);
        core_start_d = (next_state == FEED);
        core_char_d  = '0;
        if (next_state == FEED) core_char_d = (state == LOAD) ? ibuf[0] : ibuf[j_nxt[IW-1:0]];
        err_len_d     = (state == LOAD) && s_fire && (s_last != (k_cnt == LAST_IDX));
        err_timeout_d = (state == COLLECT) && !full_now && (t_cnt == T_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt <= '0;
            j_cnt <= '0;
            n_cnt <= '0;
            p_cnt <= '0;
            t_cnt <= '0;
            for (int i = 0; i < STRING_LEN; i++) begin
                ibuf[i] <= '0;
                obuf[i] <= '0;
            end
        end else begin
            if (state == LOAD && s_fire) begin
                ibuf[k_cnt[IW-1:0]] <= s_data;
                k_cnt <= (s_last || k_cnt == LAST_IDX) ? '0 : k_cnt + CW'(1);
            end
            j_cnt <= (state == FEED && !feed_last) ? j_nxt : '0;
            if (capture) begin
                obuf[n_cnt[IW-1:0]] <= core_out_char;
                n_cnt <= n_cnt + CW'(1);
            end else if (state != FEED && state != COLLECT) begin
                n_cnt <= '0;
            end
            t_cnt <= (state == COLLECT) ? t_cnt + TW'(1) : '0;
            if (m_fire) p_cnt <= (p_cnt == LAST_IDX) ? '0 : p_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_bwt_stream_ctrl.sv
// Directed bench for bwt_stream_ctrl with a reversing core stub and an expected-output queue.
module tb_bwt_stream_ctrl;
    localparam int SL  = 8;
    localparam int CW  = 8;
    localparam int TO  = 50;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [CW-1:0] s_data = '0;
    logic          core_start, core_valid_out = 1'b0;
    logic [CW-1:0] core_char, core_out_char = '0;
    logic          m_valid, m_ready = 1'b1, m_last, busy, err_len, err_timeout;
    logic [CW-1:0] m_data;

    bwt_stream_ctrl #(.STRING_LEN(SL), .CHAR_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_start(core_start), .core_char(core_char),
        .core_out_char(core_out_char), .core_valid_out(core_valid_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [CW:0] exp_q [$];
    logic [CW-1:0] feed_q [$];

    // Core stub: captures the start burst and echoes it reversed LAT cycles after the first start.
    int stub_beats = SL;
    int st_cnt = 0, st_n = 0;
    bit st_active = 1'b0;
    logic [CW-1:0] st_cap [SL];

    always @(posedge clk) begin
        #1;
        core_valid_out = 1'b0;
        core_out_char  = '0;
        if (rst) begin
            st_active = 1'b0;
            st_cnt    = 0;
            st_n      = 0;
        end else begin
            if (core_start && !st_active) begin
                st_active = 1'b1;
                st_cnt    = 0;
                st_n      = 0;
            end
            if (core_start && st_n < SL) begin
                st_cap[st_n] = core_char;
                st_n++;
            end
            if (st_active) begin
                if (st_cnt >= LAT && st_cnt < LAT + stub_beats) begin
                    core_valid_out = 1'b1;
                    core_out_char  = st_cap[SL-1-(st_cnt-LAT)];
                end
                st_cnt++;
                if (st_cnt >= LAT + SL) st_active = 1'b0;
            end
        end
    end

    // Event counters sampled mid-cycle.
    int cyc = 0, err_len_cnt = 0, err_to_cnt = 0, start_cnt = 0, mvalid_cnt = 0;
    int errmv_cnt = 0, drop_cnt = 0, last_cvo_cyc = 0, mv_rise_cyc = 0;
    int start_fall_cyc = 0, to_cyc = 0;
    logic mv_prev = 1'b0, cs_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (core_valid_out) last_cvo_cyc = cyc;
        if (m_valid && !mv_prev) mv_rise_cyc = cyc;
        if (!core_start && cs_prev) start_fall_cyc = cyc;
        if (err_timeout) begin
            err_to_cnt++;
            to_cyc = cyc;
        end
        if (err_len) err_len_cnt++;
        if (core_start) begin
            start_cnt++;
            feed_q.push_back(core_char);
        end
        if (m_valid) mvalid_cnt++;
        if ((err_len || err_timeout) && m_valid) errmv_cnt++;
        if (busy && s_ready) drop_cnt++;
        mv_prev = m_valid;
        cs_prev = core_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed timeout/unexpected event, expected normal completion", tag);
    endtask

    task automatic push_rev(input string s);
        logic [CW:0] e;
        for (int i = s.len() - 1; i >= 0; i--) begin
            e[CW-1:0] = s[i];
            e[CW]     = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Drives each character, waiting for s_ready; returns 1 ns after the final handshake edge.
    task automatic send_str(input string s, input int last_at, input int budget);
        int w;
        for (int i = 0; i < s.len(); i++) begin
            s_valid = 1'b1;
            s_data  = s[i];
            s_last  = (i == last_at);
            w = 0;
            @(negedge clk);
            while (!s_ready && w < budget) begin
                @(negedge clk);
                w++;
            end
            if (!s_ready) begin
                fail_now("s_ready_wait");
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    // Collects one output frame; mode 0 keeps m_ready high, mode 1 toggles it 1,0,1,0...
    task automatic drain(input int mode, input int budget);
        int got, w, sr_hi;
        bit tog, hold;
        logic [CW-1:0] hd;
        logic hl;
        logic [CW:0] e;
        got = 0; w = 0; sr_hi = 0; tog = 1'b1; hold = 1'b0; hd = '0; hl = 1'b0;
        while (got < SL && w < budget) begin
            m_ready = (mode == 0) ? 1'b1 : tog;
            tog = !tog;
            @(negedge clk);
            if (hold) begin
                chk("stall_m_valid", m_valid, 1);
                chk("stall_m_data", m_data, hd);
                chk("stall_m_last", m_last, hl);
            end
            if (s_ready) sr_hi++;
            hold = m_valid && !m_ready;
            hd = m_data;
            hl = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e[CW-1:0]);
                    chk("m_last", m_last, e[CW]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            w++;
        end
        m_ready = 1'b1;
        if (got < SL) fail_now("drain_timeout");
        chk("s_ready_low_in_frame", sr_hi, 0);
        chk("m_valid_after_last", m_valid, 0);
        chk("s_ready_after_last", s_ready, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, t0, s0, mv0, d0, fi, w;
        string fa;
        fa = "ABCDEFGH";

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_char", core_char, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        #2 rst = 1'b0;
        chk("s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        chk("s_ready_after_edge", s_ready, 1);

        // 1: nominal frame, m_ready held high
        e0 = err_len_cnt; t0 = err_to_cnt; s0 = start_cnt; fi = feed_q.size();
        push_rev(fa);
        send_str(fa, SL - 1, 50);
        chk("t1_start_latency", core_start, 1);
        chk("t1_first_char", core_char, 8'h41);
        chk("t1_s_ready_drop", s_ready, 0);
        drain(0, 200);
        chk("t1_feed_cycles", start_cnt - s0, SL);
        chk("t1_feed_len", feed_q.size() - fi, SL);
        if (feed_q.size() - fi >= SL)
            for (int i = 0; i < SL; i++) chk("t1_feed_char", feed_q[fi+i], fa[i]);
        chk("t1_out_latency", mv_rise_cyc - last_cvo_cyc, 1);
        chk("t1_no_err_len", err_len_cnt - e0, 0);
        chk("t1_no_err_timeout", err_to_cnt - t0, 0);

        // 2: same frame with alternating backpressure
        push_rev(fa);
        send_str(fa, SL - 1, 50);
        drain(1, 200);

        // 3: short frame, then a good one
        e0 = err_len_cnt; s0 = start_cnt;
        send_str("ABCDE", 4, 50);
        chk("t3_err_len_pulse", err_len, 1);
        @(posedge clk);
        #1;
        chk("t3_err_len_single", err_len, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_len_count", err_len_cnt - e0, 1);
        chk("t3_no_start", start_cnt - s0, 0);
        chk("t3_s_ready", s_ready, 1);
        push_rev("12345678");
        send_str("12345678", SL - 1, 50);
        drain(0, 200);

        // 4: overlong frame goes through DROP
        e0 = err_len_cnt; s0 = start_cnt; d0 = drop_cnt;
        send_str("ABCDEFGHIJ", 9, 50);
        chk("t4_drop_busy_cycles", drop_cnt - d0, 2);
        chk("t4_err_len_count", err_len_cnt - e0, 1);
        chk("t4_no_start", start_cnt - s0, 0);
        chk("t4_back_to_load_busy", busy, 0);
        chk("t4_s_ready", s_ready, 1);

        // 5: core delivers only 7 beats
        stub_beats = SL - 1;
        t0 = err_to_cnt; mv0 = mvalid_cnt;
        send_str(fa, SL - 1, 50);
        w = 0;
        while (!err_timeout && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!err_timeout) begin
            fail_now("t5_timeout_wait");
        end else begin
            @(posedge clk);
            #1;
            chk("t5_err_timeout_single", err_timeout, 0);
            chk("t5_s_ready_next", s_ready, 1);
            chk("t5_timeout_cycles", to_cyc - start_fall_cyc, TO);
        end
        chk("t5_err_timeout_count", err_to_cnt - t0, 1);
        chk("t5_no_m_valid", mvalid_cnt - mv0, 0);
        stub_beats = SL;

        // 6: reset in the 4th feed cycle, then a clean frame
        send_str(fa, SL - 1, 50);
        repeat (3) @(posedge clk);
        #3;
        chk("t6_feeding", core_start, 1);
        rst = 1'b1;
        #1;
        chk("t6_core_start_async", core_start, 0);
        chk("t6_core_char_async", core_char, 0);
        chk("t6_m_valid_async", m_valid, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_s_ready_async", s_ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        chk("t6_s_ready_at_release", s_ready, 0);
        @(posedge clk);
        #1;
        chk("t6_s_ready_one_edge", s_ready, 1);
        push_rev(fa);
        send_str(fa, SL - 1, 50);
        drain(0, 200);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("err_with_m_valid", errmv_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bwt_stream_ctrl.md
Name: bwt_stream_ctrl

Overview:
- Frame sequencer in front of the bwt_top core; one frame in flight at a time.
- Accepts STRING_LEN-character frames on an upstream valid/ready stream and buffers each one.
- Replays the buffered frame into the core as a start-qualified character burst, then collects the core's valid_out character stream.
- Presents the transformed frame on a downstream valid/ready stream with backpressure, and flags malformed frames and a stalled core.

Parameters:
STRING_LEN, 8, characters per frame (must match bwt_top STRING_LEN, >=2)
CHAR_W, 8, character width in bits
TIMEOUT, 1023, max cycles in COLLECT before the frame is abandoned

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
s_valid  in  1  upstream character valid
s_ready  out  1  upstream ready (registered)
s_data  in  CHAR_W  upstream character
s_last  in  1  upstream end-of-frame marker
core_start  out  1  to bwt_top start (registered)
core_char  out  CHAR_W  to bwt_top input_string_char (registered)
core_out_char  in  CHAR_W  from bwt_top output_string_char
core_valid_out  in  1  from bwt_top valid_out
m_valid  out  1  downstream character valid
m_ready  in  1  downstream ready
m_data  out  CHAR_W  downstream character
m_last  out  1  asserted with the final character of a frame
busy  out  1  high in every state except LOAD
err_len  out  1  one-cycle pulse, frame length error
err_timeout  out  1  one-cycle pulse, core did not complete the frame

Behaviour:
- Reset (async, immediate): state=LOAD, all counters 0, and every output is 0, including s_ready. s_ready rises on the first clock edge after rst deasserts.
- Counters are $clog2(STRING_LEN+1) bits. The timeout counter is $clog2(TIMEOUT+1) bits. Buffers are STRING_LEN x CHAR_W registers.
- LOAD:
  - s_ready=1. Each s_valid&&s_ready beat writes ibuf[k], then k++.
  - s_last on beat k=STRING_LEN-1: accept, s_ready drops next cycle, go FEED.
  - s_last on beat k<STRING_LEN-1: err_len pulse next cycle, discard frame, k=0, stay LOAD.
  - Beat k=STRING_LEN-1 without s_last: err_len pulse, go DROP.
- DROP: s_ready=1; accept and discard beats. The beat carrying s_last is discarded, then go LOAD with k=0.
- FEED:
  - core_start=1 for exactly STRING_LEN consecutive cycles, starting the cycle after the last input handshake.
  - core_char=ibuf[j] in feed cycle j.
  - After the last feed cycle, core_start=0 and core_char=0, go COLLECT.
  - Any core_valid_out during FEED is captured the same as in COLLECT.
- COLLECT:
  - Each core_valid_out cycle writes obuf[n]=core_out_char, then n++.
  - At n==STRING_LEN, go DRAIN.
  - Timeout counter counts COLLECT cycles. When it reaches TIMEOUT before the frame completes: err_timeout pulse, discard, go LOAD (s_ready=1 next cycle).
  - Any core_valid_out outside FEED/COLLECT is ignored.
- DRAIN:
  - m_valid=1, m_data=obuf[p], m_last=(p==STRING_LEN-1).
  - Advance p on m_valid&&m_ready. m_data and m_last are held stable while m_ready=0.
  - After the m_last handshake: m_valid=0, go LOAD, s_ready=1 next cycle.
  - m_valid never deasserts without a handshake.
- busy=1 in FEED, COLLECT, DRAIN and DROP.
- Error pulses never coincide with m_valid.
- Latency (core ideal, m_ready=1): last s handshake -> core_start high is 1 cycle. Final core_valid_out -> m_valid high is 1 cycle.
- Simultaneous events:
  - core_valid_out on the last feed cycle is captured.
  - A timeout on the same cycle as the final core beat counts as completion, with no err_timeout.
- Reset mid-operation: all state is abandoned, core_start drops asynchronously, and partial buffers are never emitted.

Test Plan:
1. Core stub echoes the frame reversed, 20 cycles after its first start. Input "ABCDEFGH", s_last on 'H', m_ready=1 -> core_start high 8 cycles with core_char A..H; m stream "HGFEDCBA", m_last only on 'A'; no error pulses.
2. Same frame, m_ready pattern 1,0,1,0... -> exactly 8 handshakes, m_data stable across stalls, s_ready=0 until the cycle after 'A' is accepted.
3. s_last on 5th beat "ABCDE" -> err_len single pulse, core_start never asserted; following "12345678" frame processed normally ("87654321").
4. 10-beat frame with s_last on beat 10 -> err_len pulse after beat 8, beats 9-10 consumed by DROP, busy=1 during DROP, no core_start.
5. Stub emits only 7 core_valid_out beats, TIMEOUT=50 -> err_timeout pulse exactly 50 cycles after entering COLLECT, m_valid never asserted, s_ready=1 on the next cycle.
6. Assert rst during the 4th FEED cycle -> core_start=0, m_valid=0 and busy=0 immediately; s_ready=1 one edge after release; next frame "ABCDEFGH" -> "HGFEDCBA".
